cp0_unit: RTL and testbench

//  Parametrised CP0 system-control block for the MIPS pipeline.
//  - Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  - Takes MTC0 writes, exception commits and ERET from the MEM/WB boundary.
//  - Generates the timer interrupt and the masked interrupt request to the exception logic.
//  - Next generation: adds a configurable interrupt count, Count prescaler, write masks and an ERET path.

---
 rtl/cp0_unit.sv | 128 ++++++++++++
 tb/tb_cp0_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// CP0 system-control block: BadVAddr, Count/Compare timer, Status, Cause and EPC.
// Takes MTC0 writes, exception commits and ERET, and raises the masked interrupt request.
module cp0_unit #(
    parameter int unsigned HW_INT_NUM = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter int unsigned TIMER_LINE = 5,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [HW_INT_NUM-1:0] hw_int_i,
    input  logic                  excp_valid_i,
    input  logic [4:0]            excp_code_i,
    input  logic [31:0]           excp_pc_i,
    input  logic                  excp_in_ds_i,
    input  logic [31:0]           excp_bva_i,
    input  logic                  eret_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  timer_int_o
);

    logic [31:0] badvaddr, count, compare, epc;
    logic [3:0]  presc;
    logic [7:0]  im;
    logic        exl, ie, bd, ti;
    logic [5:0]  ip_hw, ip_next;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;

    logic tick, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    always_comb begin
        ip_next             = 6'(hw_int_i);
        ip_next[TIMER_LINE] = ip_next[TIMER_LINE] | ti;
        tick       = (presc == 4'(COUNT_DIV - 1));
        wr_count   = we_i && (waddr_i == 5'd9);
        wr_compare = we_i && (waddr_i == 5'd11);
        wr_status  = we_i && (waddr_i == 5'd12);
        wr_cause   = we_i && (waddr_i == 5'd13);
        wr_epc     = we_i && (waddr_i == 5'd14);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            epc      <= '0;
            presc    <= '0;
            im       <= STATUS_RST[15:8];
            exl      <= STATUS_RST[1];
            ie       <= STATUS_RST[0];
            bd       <= 1'b0;
            ti       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
        end else begin
            ip_hw <= ip_next;

            if (wr_count) begin
                count <= wdata_i;
                presc <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + 4'd1;
            end

            // A Compare write clears TI even when a match lands in the same cycle
            if (wr_compare) begin
                compare <= wdata_i;
                ti      <= 1'b0;
            end else if (tick && !wr_count && (count + 32'd1 == compare)) begin
                ti <= 1'b1;
            end

            if (wr_status) begin
                im  <= wdata_i[15:8];
                exl <= wdata_i[1];
                ie  <= wdata_i[0];
            end
            if (wr_cause) ip_sw <= wdata_i[9:8];
            if (wr_epc)   epc   <= wdata_i;

            // Later assignments override MTC0 on shared fields: exception > ERET > MTC0
            if (excp_valid_i) begin
                exl      <= 1'b1;
                exc_code <= excp_code_i;
                if (!exl) begin
                    epc <= excp_in_ds_i ? excp_pc_i - 32'd4 : excp_pc_i;
                    bd  <= excp_in_ds_i;
                end
                if (excp_code_i == 5'd4 || excp_code_i == 5'd5)
                    badvaddr <= excp_bva_i;
            end else if (eret_i) begin
                exl <= 1'b0;
            end
        end
    end

    always_comb begin
        status_o    = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
        cause_o     = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
        epc_o       = epc;
        timer_int_o = ti;
        int_req_o   = ie & ~exl & |({ip_hw, ip_sw} & im);
        unique case (raddr_i)
            5'd8:    rdata_o = badvaddr;
            5'd9:    rdata_o = count;
            5'd11:   rdata_o = compare;
            5'd12:   rdata_o = status_o;
            5'd13:   rdata_o = cause_o;
            5'd14:   rdata_o = epc;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit with default parameters.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  hw_int_i;
    logic        excp_valid_i;
    logic [4:0]  excp_code_i;
    logic [31:0] excp_pc_i;
    logic        excp_in_ds_i;
    logic [31:0] excp_bva_i;
    logic        eret_i;
    logic [31:0] status_o, cause_o, epc_o;
    logic        int_req_o, timer_int_o;

    int checks = 0;
    int errors = 0;

    cp0_unit #(
        .HW_INT_NUM(6),
        .COUNT_DIV (2),
        .TIMER_LINE(5),
        .STATUS_RST(32'h0040_0000)
    ) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
        .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .excp_pc_i(excp_pc_i),
        .excp_in_ds_i(excp_in_ds_i), .excp_bva_i(excp_bva_i), .eret_i(eret_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
        .int_req_o(int_req_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
        raddr_i = a;
        #1;
        check(tag, rdata_o, exp);
    endtask

    task automatic excp(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bva);
        excp_valid_i = 1'b1; excp_code_i = code; excp_pc_i = pc;
        excp_in_ds_i = ds; excp_bva_i = bva;
        step();
        excp_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        hw_int_i = '0; excp_valid_i = 1'b0; excp_code_i = '0; excp_pc_i = '0;
        excp_in_ds_i = 1'b0; excp_bva_i = '0; eret_i = 1'b0;
        repeat (3) step();

        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_int_req", 32'(int_req_o), 32'h0);
        check("rst_timer", 32'(timer_int_o), 32'h0);
        mfc0("rst_count", 5'd9, 32'h0);
        rst = 1'b0;

        // Timer match 10 cycles after Count write
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (9) step();
        check("ti_early", 32'(timer_int_o), 32'h0);
        step();
        check("ti_set", 32'(timer_int_o), 32'h1);
        check("ti_cause", 32'(cause_o[30]), 32'h1);
        mfc0("ti_count", 5'd9, 32'd5);
        mtc0(5'd11, 32'd100);
        check("ti_clear", 32'(timer_int_o), 32'h0);
        mfc0("compare_rd", 5'd11, 32'd100);

        // Hardware interrupt through IM
        mtc0(5'd12, 32'h0000_8001);
        check("status_wr", status_o, 32'h0040_8001);
        check("no_req", 32'(int_req_o), 32'h0);
        hw_int_i = 6'b100000;
        step();
        check("ip7", 32'(cause_o[15]), 32'h1);
        check("int_req", 32'(int_req_o), 32'h1);
        mtc0(5'd12, 32'h0000_8003);
        check("exl_mask", 32'(int_req_o), 32'h0);
        hw_int_i = '0;
        mtc0(5'd12, 32'h0);

        // Address error in delay slot
        excp(5'd4, 32'hBFC0_0100, 1'b1, 32'h0000_1003);
        check("e1_epc", epc_o, 32'hBFC0_00FC);
        check("e1_cause", cause_o, 32'h8000_0010);
        check("e1_status", status_o, 32'h0040_0002);
        mfc0("e1_bva", 5'd8, 32'h0000_1003);

        // Nested exception leaves EPC/BD alone
        excp(5'd8, 32'h0000_0100, 1'b0, 32'hFFFF_FFFF);
        check("e2_epc", epc_o, 32'hBFC0_00FC);
        check("e2_cause", cause_o, 32'h8000_0020);
        mfc0("e2_bva", 5'd8, 32'h0000_1003);
        eret_i = 1'b1; step(); eret_i = 1'b0;
        check("eret", status_o, 32'h0040_0000);

        // Same-cycle priority
        mtc0(5'd12, 32'h0000_FF01);
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0;
        excp(5'd12, 32'h0000_2000, 1'b0, 32'h0);
        we_i = 1'b0;
        check("pri_status", status_o, 32'h0040_0002);
        check("pri_epc", epc_o, 32'h0000_2000);
        check("pri_cause", cause_o, 32'h0000_0030);
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_1234; eret_i = 1'b1;
        step();
        we_i = 1'b0; eret_i = 1'b0;
        check("eret_epc", epc_o, 32'h0000_1234);
        check("eret_status", status_o, 32'h0040_0000);

        // Write masks, read-only and unmapped registers
        mtc0(5'd12, 32'hFFFF_FFFF);
        mfc0("status_mask", 5'd12, 32'h0040_FF03);
        mtc0(5'd8, 32'h0000_DEAD);
        mfc0("bva_ro", 5'd8, 32'h0000_1003);
        mtc0(5'd7, 32'hFFFF_FFFF);
        mfc0("unmapped", 5'd7, 32'h0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_mask", cause_o, 32'h0000_0330);
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_5555;
        mfc0("no_fwd", 5'd14, 32'h0000_1234);
        step();
        we_i = 1'b0;
        mfc0("epc_wr", 5'd14, 32'h0000_5555);

        // Count wrap matches Compare = 0, TI reaches IP7 one cycle later
        mtc0(5'd11, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        check("wrap_pre", 32'(timer_int_o), 32'h0);
        step();
        check("wrap_ti", 32'(timer_int_o), 32'h1);
        mfc0("wrap_count", 5'd9, 32'h0);
        step();
        check("wrap_ip7", cause_o, 32'h4000_8330);

        // Reset mid-operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_status", status_o, 32'h0040_0000);
        check("rst2_cause", cause_o, 32'h0);
        check("rst2_timer", 32'(timer_int_o), 32'h0);
        mfc0("rst2_count", 5'd9, 32'h0);
        step();
        mfc0("rst2_presc", 5'd9, 32'h0);
        step();
        mfc0("rst2_tick", 5'd9, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
